// File: rtl/tabuleiro.sv
// Seven-by-six drop-piece board: accepts one move per active pulse, writes the cell, checks four lines for a win or draw.
// Accept responds 7 cycles after the request edge, reject after 2; one response per active assertion, then waits for active to drop.
module tabuleiro #(
  parameter int N_COL   = 7,
  parameter int N_LIN   = 6,
  parameter int WIN_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  input  logic [2:0] coluna_in,
  input  logic [1:0] player_in,
  output logic [1:0] response_ctl,
  output logic       wr_en,
  output logic [2:0] wr_linha,
  output logic [2:0] wr_coluna,
  output logic [1:0] wr_player,
  input  logic [2:0] rd_linha,
  input  logic [2:0] rd_coluna,
  output logic [1:0] rd_cell,
  output logic       game_over,
  output logic [1:0] vencedor
);

  typedef enum logic [3:0] {
    IDLE, FIND, WRITE, CHK_H, CHK_V, CHK_D1, CHK_D2, RESP_OK, RESP_REJ, RELEASE
  } state_t;

  localparam logic [2:0] LIN_LIM = 3'(N_LIN);
  localparam logic [2:0] COL_LIM = 3'(N_COL);
  localparam logic [5:0] CELLS   = 6'(N_LIN * N_COL);

  state_t     state_q;
  logic [1:0] cell_q   [N_LIN][N_COL];
  logic [2:0] altura_q [N_COL];
  logic [5:0] pieces_q;
  logic [2:0] col_q, row_q;
  logic [1:0] pl_q;
  logic       win_q;
  logic [1:0] response_ctl_q;
  logic       wr_en_q;
  logic [2:0] wr_linha_q, wr_coluna_q;
  logic [1:0] wr_player_q;
  logic       game_over_q;
  logic [1:0] vencedor_q;

  int   dr_d, dc_d, line_d;
  logic win_d, reject_d;

  // Same-owner run length stepping away from the just-written cell; leaving the board ends the run.
  function automatic int run_len(int dr, int dc);
    int   r, c, n;
    logic go;
    n  = 0;
    go = 1'b1;
    for (int i = 1; i < WIN_LEN; i++) begin
      r = int'(row_q) + i * dr;
      c = int'(col_q) + i * dc;
      if (go && r >= 0 && r < N_LIN && c >= 0 && c < N_COL && cell_q[r[2:0]][c[2:0]] == pl_q)
        n = n + 1;
      else
        go = 1'b0;
    end
    return n;
  endfunction

  always_comb begin
    dr_d = 0;
    dc_d = 1;
    case (state_q)
      CHK_V:   begin dr_d = 1; dc_d = 0;  end
      CHK_D1:  begin dr_d = 1; dc_d = 1;  end
      CHK_D2:  begin dr_d = 1; dc_d = -1; end
      default: begin dr_d = 0; dc_d = 1;  end
    endcase
    line_d   = 1 + run_len(dr_d, dc_d) + run_len(-dr_d, -dc_d);
    win_d    = (line_d >= WIN_LEN);
    reject_d = game_over_q || (col_q >= COL_LIM) || !(pl_q == 2'd1 || pl_q == 2'd2)
               || (altura_q[col_q] >= LIN_LIM);
    rd_cell  = (rd_linha < LIN_LIM && rd_coluna < COL_LIM) ? cell_q[rd_linha][rd_coluna] : 2'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      for (int r = 0; r < N_LIN; r++)
        for (int c = 0; c < N_COL; c++)
          cell_q[r][c] <= 2'd0;
      for (int c = 0; c < N_COL; c++)
        altura_q[c] <= 3'd0;
      pieces_q       <= 6'd0;
      col_q          <= 3'd0;
      row_q          <= 3'd0;
      pl_q           <= 2'd0;
      win_q          <= 1'b0;
      response_ctl_q <= 2'd0;
      wr_en_q        <= 1'b0;
      wr_linha_q     <= 3'd0;
      wr_coluna_q    <= 3'd0;
      wr_player_q    <= 2'd0;
      game_over_q    <= 1'b0;
      vencedor_q     <= 2'd0;
    end else begin
      response_ctl_q <= 2'd0;
      wr_en_q        <= 1'b0;
      case (state_q)
        IDLE: if (active) begin
          col_q   <= coluna_in;
          pl_q    <= player_in;
          win_q   <= 1'b0;
          state_q <= FIND;
        end
        FIND: begin
          row_q   <= altura_q[col_q];
          state_q <= reject_d ? RESP_REJ : WRITE;
        end
        WRITE: begin
          cell_q[row_q][col_q] <= pl_q;
          altura_q[col_q]      <= row_q + 3'd1;
          pieces_q             <= pieces_q + 6'd1;
          wr_en_q              <= 1'b1;
          wr_linha_q           <= row_q;
          wr_coluna_q          <= col_q;
          wr_player_q          <= pl_q;
          state_q              <= CHK_H;
        end
        CHK_H:  begin win_q <= win_q | win_d; state_q <= CHK_V;  end
        CHK_V:  begin win_q <= win_q | win_d; state_q <= CHK_D1; end
        CHK_D1: begin win_q <= win_q | win_d; state_q <= CHK_D2; end
        CHK_D2: begin
          win_q   <= win_q | win_d;
          // Piece count already includes this move, so a full board with no line is a draw.
          if (win_q || win_d) begin
            game_over_q <= 1'b1;
            vencedor_q  <= pl_q;
          end else if (pieces_q == CELLS) begin
            game_over_q <= 1'b1;
            vencedor_q  <= 2'd3;
          end
          state_q <= RESP_OK;
        end
        RESP_OK:  begin response_ctl_q <= 2'd2; state_q <= RELEASE; end
        RESP_REJ: begin response_ctl_q <= 2'd1; state_q <= RELEASE; end
        RELEASE:  if (!active) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign response_ctl = response_ctl_q;
  assign wr_en        = wr_en_q;
  assign wr_linha     = wr_linha_q;
  assign wr_coluna    = wr_coluna_q;
  assign wr_player    = wr_player_q;
  assign game_over    = game_over_q;
  assign vencedor     = vencedor_q;

endmodule

// File: tb/tb_tabuleiro.sv
// Directed bench for tabuleiro: move latency, column overflow, row/diagonal wins, full-board draw, reset.
module tb_tabuleiro;
  logic       clk = 1'b0;
  logic       reset, active;
  logic [2:0] coluna_in, rd_linha, rd_coluna;
  logic [1:0] player_in;
  logic [1:0] response_ctl, wr_player, rd_cell, vencedor;
  logic       wr_en, game_over;
  logic [2:0] wr_linha, wr_coluna;

  tabuleiro dut (
    .clk(clk), .reset(reset), .active(active), .coluna_in(coluna_in), .player_in(player_in),
    .response_ctl(response_ctl), .wr_en(wr_en), .wr_linha(wr_linha), .wr_coluna(wr_coluna),
    .wr_player(wr_player), .rd_linha(rd_linha), .rd_coluna(rd_coluna), .rd_cell(rd_cell),
    .game_over(game_over), .vencedor(vencedor)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int resp, resp_cyc, wr_cyc, npulse, n_ok, v;
  int wl, wc, wp;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic peek(input int r, input int c, output int val);
    rd_linha  = 3'(r);
    rd_coluna = 3'(c);
    #1;
    val = int'(rd_cell);
  endtask

  // Cycle index i is counted from the edge that first sees active=1 (i=0 is just after that edge).
  task automatic do_move(input logic [2:0] c, input logic [1:0] p, input int hold);
    resp = 0; resp_cyc = -1; wr_cyc = -1; npulse = 0;
    wl = -1; wc = -1; wp = -1;
    @(negedge clk);
    active = 1'b1; coluna_in = c; player_in = p;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        coluna_in = ~c;
        player_in = ~p;
      end
      if (response_ctl != 2'd0) begin
        npulse++;
        resp = int'(response_ctl);
        resp_cyc = i;
      end
      if (wr_en) begin
        wr_cyc = i; wl = int'(wr_linha); wc = int'(wr_coluna); wp = int'(wr_player);
      end
    end
    @(negedge clk);
    active = 1'b0;
    @(posedge clk);
  endtask

  task automatic expect_ok(input string tag, input logic [2:0] c, input logic [1:0] p);
    do_move(c, p, 10);
    check({tag, " resp"}, resp, 2);
    check({tag, " resp_cyc"}, resp_cyc, 7);
    check({tag, " wr_cyc"}, wr_cyc, 2);
  endtask

  task automatic expect_rej(input string tag, input logic [2:0] c, input logic [1:0] p);
    do_move(c, p, 10);
    check({tag, " resp"}, resp, 1);
    check({tag, " resp_cyc"}, resp_cyc, 2);
    check({tag, " wr_cyc"}, wr_cyc, -1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    active = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; active = 1'b0; coluna_in = 3'd0; player_in = 2'd0;
    rd_linha = 3'd0; rd_coluna = 3'd0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst response_ctl", int'(response_ctl), 0);
    check("rst wr_en", int'(wr_en), 0);
    check("rst wr_linha", int'(wr_linha), 0);
    check("rst game_over", int'(game_over), 0);
    check("rst vencedor", int'(vencedor), 0);
    peek(0, 3, v); check("rst rd(0,3)", v, 0);
    @(posedge clk); #2 reset = 1'b1;

    // First move right after reset; inputs scrambled after the latch edge
    expect_ok("m1", 3'd3, 2'd1);
    check("m1 wr_linha", wl, 0);
    check("m1 wr_coluna", wc, 3);
    check("m1 wr_player", wp, 1);
    check("m1 pulses", npulse, 1);
    peek(0, 3, v); check("m1 rd(0,3)", v, 1);
    peek(1, 3, v); check("m1 rd(1,3)", v, 0);

    // Column overflow
    do_reset();
    for (int i = 0; i < 6; i++) begin
      expect_ok("col0 fill", 3'd0, 2'(1 + (i % 2)));
      check("col0 fill row", wl, i);
    end
    expect_rej("col0 full", 3'd0, 2'd1);
    expect_rej("col0 full again", 3'd0, 2'd2);
    peek(5, 0, v); check("col0 rd(5,0)", v, 2);
    peek(6, 0, v); check("rd row 6 out of range", v, 0);
    peek(0, 7, v); check("rd col 7 out of range", v, 0);
    check("col0 game_over", int'(game_over), 0);

    // Bad requests and a long-held active
    expect_rej("col 7", 3'd7, 2'd1);
    expect_rej("player 0", 3'd2, 2'd0);
    expect_rej("player 3", 3'd2, 2'd3);
    do_move(3'd4, 2'd2, 20);
    check("hold20 pulses", npulse, 1);
    check("hold20 resp", resp, 2);
    peek(0, 4, v); check("hold20 rd(0,4)", v, 2);

    // Horizontal win for player 1 on row 0
    do_reset();
    expect_ok("h1", 3'd0, 2'd1);
    expect_ok("h2", 3'd0, 2'd2);
    expect_ok("h3", 3'd1, 2'd1);
    expect_ok("h4", 3'd1, 2'd2);
    expect_ok("h5", 3'd2, 2'd1);
    expect_ok("h6", 3'd2, 2'd2);
    check("h pre game_over", int'(game_over), 0);
    expect_ok("h7", 3'd3, 2'd1);
    check("h game_over", int'(game_over), 1);
    check("h vencedor", int'(vencedor), 1);
    expect_rej("h after win", 3'd5, 2'd2);
    peek(0, 5, v); check("h rd(0,5)", v, 0);

    // Rising diagonal for player 2 with player-1 fillers
    do_reset();
    expect_ok("d (0,0)", 3'd0, 2'd2);
    expect_ok("d f(0,1)", 3'd1, 2'd1);
    expect_ok("d (1,1)", 3'd1, 2'd2);
    expect_ok("d f(0,2)", 3'd2, 2'd1);
    expect_ok("d f(1,2)", 3'd2, 2'd1);
    expect_ok("d (2,2)", 3'd2, 2'd2);
    expect_ok("d f(0,3)", 3'd3, 2'd1);
    expect_ok("d f(1,3)", 3'd3, 2'd1);
    expect_ok("d f(2,3)", 3'd3, 2'd1);
    check("d pre game_over", int'(game_over), 0);
    expect_ok("d (3,3)", 3'd3, 2'd2);
    check("d game_over", int'(game_over), 1);
    check("d vencedor", int'(vencedor), 2);

    // Full board, no line of four: owner = 1 + (((r>>1)&1) ^ (c&1))
    do_reset();
    n_ok = 0;
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) begin
        do_move(3'(c), 2'(1 + (((r >> 1) & 1) ^ (c & 1))), 10);
        if (resp == 2) n_ok++;
        if (c == 6 && r == 4) check("draw 41 game_over", int'(game_over), 0);
      end
    end
    check("draw accepted", n_ok, 42);
    check("draw game_over", int'(game_over), 1);
    check("draw vencedor", int'(vencedor), 3);
    expect_rej("draw after end", 3'd0, 2'd1);

    // Asynchronous reset clears everything
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst game_over", int'(game_over), 0);
    check("arst vencedor", int'(vencedor), 0);
    peek(0, 0, v); check("arst rd(0,0)", v, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/tabuleiro.md
TABULEIRO -- requirements
Module: tabuleiro

Interface
REQ-001 Parameter: N_COL, 7, board columns (0..6, matches the 3-bit column code).
REQ-002 Parameter: N_LIN, 6, board rows (0 = bottom).
REQ-003 Parameter: WIN_LEN, 4, aligned pieces needed to win.
REQ-004 Port: clk  in  1  system clock, rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low; clears all state.
REQ-006 Port: active  in  1  move request from the button FSM, held high until response seen.
REQ-007 Port: coluna_in  in  3  requested column, valid while active=1.
REQ-008 Port: player_in  in  2  moving player, 1 or 2, valid while active=1.
REQ-009 Port: response_ctl  out  2  0 none, 1 move rejected, 2 move accepted; one-cycle pulse.
REQ-010 Port: wr_en  out  1  one-cycle pulse when a cell is written (video update).
REQ-011 Port: wr_linha / wr_coluna / wr_player  out  3/3/2  written cell row, column, owner; valid with wr_en.
REQ-012 Port: rd_linha, rd_coluna  in  3/3  combinational read address for video.
REQ-013 Port: rd_cell  out  2  cell owner at read address (0 empty); 0 for out-of-range address.
REQ-014 Port: game_over  out  1  game finished; stays high until reset.
REQ-015 Port: vencedor  out  2  0 none, 1/2 winner, 3 draw; valid when game_over=1.

Function
REQ-016 Storage: 42 cells x 2 bits plus per-column height counter altura[c], 0..6.
REQ-017 States: IDLE, FIND, WRITE, CHK_H, CHK_V, CHK_D1, CHK_D2, RESP_OK, RESP_REJ, RELEASE.
REQ-018 IDLE: active=1 at edge k -> latch coluna_in, player_in; enter FIND.
REQ-019 FIND -> RESP_REJ if game_over=1, coluna>6, player not in {1,2}, or altura[col]=6; else -> WRITE.
REQ-020 WRITE: cell[altura[col]][col] <= player, altura[col]++, wr_en=1 with wr_linha=old altura; -> CHK_H.
REQ-021 CHK_H/CHK_V/CHK_D1(/)/CHK_D2(\): one cycle each; count same-owner contiguous cells both sides of the written cell (up to WIN_LEN-1 each side, out-of-board counts as stop); count+1 >= WIN_LEN sets win flag.
REQ-022 After CHK_D2 -> RESP_OK; response_ctl=2 for exactly that cycle.
REQ-023 On entering RESP_OK: win flag -> game_over=1, vencedor=player; else if total pieces = 42 -> game_over=1, vencedor=3.
REQ-024 RESP_REJ: response_ctl=1 for exactly one cycle, board unchanged, no wr_en.
REQ-025 RESP_OK/RESP_REJ -> RELEASE; RELEASE waits for active=0 then -> IDLE (one request per active assertion).
REQ-026 Latency: response_ctl=2 visible 7 cycles after edge k; response_ctl=1 visible 2 cycles after edge k.
REQ-027 Inputs changing after edge k have no effect on the move in progress.
REQ-028 response_ctl=0 and wr_en=0 in all states except those named above.
REQ-029 game_over=1: every later request rejected (response_ctl=1).

Reset
REQ-030 reset=0 asynchronously forces IDLE, all cells 0, all altura 0, piece count 0, win flag 0.
REQ-031 During reset: response_ctl=0, wr_en=0, wr_* = 0, game_over=0, vencedor=0; reset mid-move aborts with no response.
REQ-032 First request accepted on the first rising edge after reset deasserts.

Verification
REQ-033 After reset, active=1, col 3, player 1 -> wr_en at cycle k+2 with row 0 col 3 player 1; response_ctl=2 at k+7; rd(0,3)=1.
REQ-034 Six moves in col 0 accepted, seventh -> response_ctl=1 at k+2, no wr_en, altura[0] stays 6.
REQ-035 Player 1 at cols 0,1,2,3 row 0 (player 2 elsewhere, no win) -> after 4th move game_over=1, vencedor=1; next request -> response_ctl=1.
REQ-036 Diagonal: player 2 at (0,0),(1,1),(2,2),(3,3) built with fillers -> vencedor=2 at RESP_OK of last move.
REQ-037 Fill all 42 cells without four-in-line -> game_over=1, vencedor=3.
REQ-038 Hold active=1 for 20 cycles -> exactly one response pulse; coluna_in=7 or player_in=0 -> response_ctl=1.
